// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Y86-64 SEQ fetch stage with PC register and byte-wide memory port
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [63:0] new_pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] ValC,
  output logic [63:0] ValP,
  output logic [2:0]  stat,
  output logic        instr_valid
);

  typedef enum logic [1:0] {S_FETCH, S_DONE, S_HALT, S_ERR} state_t;

  localparam logic [2:0]  STAT_AOK   = 3'd1;
  localparam logic [2:0]  STAT_HLT   = 3'd2;
  localparam logic [2:0]  STAT_ADR   = 3'd3;
  localparam logic [2:0]  STAT_INS   = 3'd4;
  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_SIZE);

  // Total encoded length in bytes for a legal icode.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  // Whether the icode/ifun pair names a real instruction.
  function automatic logic instr_legal(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7:                   instr_legal = (fn <= 4'd6);
      4'h6:                         instr_legal = (fn <= 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF:       instr_legal = 1'b0;
      default:                      instr_legal = (fn == 4'd0);
    endcase
  endfunction

  // Instructions whose byte 1 carries rA/rB.
  function automatic logic has_regbyte(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regbyte = 1'b1;
      default:                                  has_regbyte = 1'b0;
    endcase
  endfunction

  // Byte index where the 8-byte constant starts; 0 means no constant.
  function automatic logic [3:0] valc_base(input logic [3:0] ic);
    case (ic)
      4'h7, 4'h8:       valc_base = 4'd1;
      4'h3, 4'h4, 4'h5: valc_base = 4'd2;
      default:          valc_base = 4'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  len_q, len_d;
  logic        req_q, req_d;
  logic [63:0] addr_q, addr_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d;
  logic [2:0]  stat_q, stat_d;

  logic        issue_ok, issue_bad, accept, byte_err, byte_ok, is_first, illegal;
  logic        last_byte, more, next_bad;
  logic [3:0]  cur_icode, cur_len, vbase;
  logic [63:0] cur_addr, next_addr;

  // Fetch events shared by the FSM and the datapath.
  always_comb begin
    cur_addr  = pc_q + 64'(cnt_q);
    next_addr = cur_addr + 64'd1;
    issue_ok  = (state_q == S_FETCH) && !req_q && (cur_addr < IMEM_LIMIT);
    issue_bad = (state_q == S_FETCH) && !req_q && (cur_addr >= IMEM_LIMIT);
    accept    = (state_q == S_FETCH) && req_q && mem_ack;
    byte_err  = accept && mem_err;
    byte_ok   = accept && !mem_err;
    is_first  = (cnt_q == 4'd0);
    cur_icode = is_first ? mem_rdata[7:4] : icode_q;
    cur_len   = is_first ? instr_len(mem_rdata[7:4]) : len_q;
    illegal   = is_first && !instr_legal(mem_rdata[7:4], mem_rdata[3:0]);
    last_byte = byte_ok && !illegal && ((cnt_q + 4'd1) == cur_len);
    more      = byte_ok && !illegal && !last_byte;
    next_bad  = more && (next_addr >= IMEM_LIMIT);
    vbase     = valc_base(cur_icode);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; HALT and ERR are left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (issue_bad || byte_err || next_bad || (byte_ok && illegal)) state_d = S_ERR;
        else if (last_byte) state_d = (cur_icode == 4'h0) ? S_HALT : S_DONE;
      end
      S_DONE:  if (pc_load) state_d = S_FETCH;
      default: state_d = state_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
      len_q   <= 4'd1;
      req_q   <= 1'b0;
      addr_q  <= 64'd0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= STAT_AOK;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
    end
  end

  // Datapath next values: request sequencing, byte decode and PC reload.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    req_d   = req_q;
    addr_d  = addr_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    stat_d  = stat_q;
    if (issue_ok) begin
      req_d  = 1'b1;
      addr_d = cur_addr;
    end
    if (issue_bad) stat_d = STAT_ADR;
    if (byte_err) begin
      req_d  = 1'b0;
      addr_d = 64'd0;
      stat_d = STAT_ADR;
    end
    if (byte_ok) begin
      if (is_first) begin
        icode_d = mem_rdata[7:4];
        ifun_d  = mem_rdata[3:0];
        len_d   = cur_len;
      end
      if (illegal) begin
        req_d  = 1'b0;
        addr_d = 64'd0;
        stat_d = STAT_INS;
        valp_d = pc_q + 64'd1;
      end else begin
        if ((cnt_q == 4'd1) && has_regbyte(icode_q)) begin
          ra_d = mem_rdata[7:4];
          rb_d = mem_rdata[3:0];
        end
        if ((vbase != 4'd0) && (cnt_q >= vbase)) begin
          for (int k = 0; k < 8; k++) begin
            if ((cnt_q - vbase) == 4'(k)) valc_d[8*k +: 8] = mem_rdata;
          end
        end
        if (last_byte) begin
          req_d  = 1'b0;
          addr_d = 64'd0;
          valp_d = pc_q + 64'(cur_len);
          stat_d = (cur_icode == 4'h0) ? STAT_HLT : STAT_AOK;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (next_bad) begin
            req_d  = 1'b0;
            addr_d = 64'd0;
            stat_d = STAT_ADR;
          end else begin
            addr_d = next_addr;
          end
        end
      end
    end
    if ((state_q == S_DONE) && pc_load) begin
      pc_d   = new_pc;
      cnt_d  = 4'd0;
      ra_d   = 4'hF;
      rb_d   = 4'hF;
      valc_d = 64'd0;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    mem_req     = req_q;
    mem_addr    = addr_q;
    pc          = pc_q;
    icode       = icode_q;
    ifun        = ifun_q;
    rA          = ra_q;
    rB          = rb_q;
    ValC        = valc_q;
    ValP        = valp_q;
    stat        = stat_q;
    instr_valid = (state_q != S_FETCH);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a byte memory responder
module tb_fetch_unit;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } res_t;

  logic        clk, rst_n, pc_load;
  logic [63:0] new_pc;
  logic        mem_req, mem_ack, mem_err, instr_valid;
  logic [63:0] mem_addr, pc, ValC, ValP;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;

  logic        rst2_n, req2, ack2, valid2;
  logic [63:0] addr2, pc2, valc2, valp2;
  logic [7:0]  rdata2;
  logic [3:0]  icode2, ifun2, ra2, rb2;
  logic [2:0]  stat2;

  logic [7:0]  mem [0:1023];
  logic [63:0] acked[$];
  logic [63:0] err_addr;
  int          max_delay, n2_acks, n2_bad;
  bit          late_ack_en;
  int          n_checks, n_pass;
  res_t        rst_res, prev;

  fetch_unit #(.RESET_PC(64'd0), .IMEM_SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .new_pc(new_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .pc(pc), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .ValC(ValC), .ValP(ValP), .stat(stat), .instr_valid(instr_valid));

  fetch_unit #(.RESET_PC(64'd1022), .IMEM_SIZE(1024)) dut2 (
    .clk(clk), .rst_n(rst2_n), .pc_load(1'b0), .new_pc(64'd0),
    .mem_req(req2), .mem_addr(addr2), .mem_rdata(rdata2),
    .mem_ack(ack2), .mem_err(1'b0), .pc(pc2), .icode(icode2), .ifun(ifun2),
    .rA(ra2), .rB(rb2), .ValC(valc2), .ValP(valp2), .stat(stat2), .instr_valid(valid2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder for dut: random ack latency, optional fault address.
  initial begin : responder
    int wait_cnt;
    wait_cnt = -1;
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = late_ack_en; mem_err = 1'b0; mem_rdata = 8'hFF; wait_cnt = -1;
      end else if (mem_req) begin
        if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, max_delay));
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = (mem_addr < 64'd1024) ? mem[mem_addr[9:0]] : 8'h00;
          mem_err   = (mem_addr == err_addr);
          acked.push_back(mem_addr);
          wait_cnt  = -1;
        end else begin
          mem_ack = 1'b0; mem_err = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
          wait_cnt--;
        end
      end else begin
        mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 8'($urandom);
      end
    end
  end

  // Memory responder for dut2: zero latency, counts requests past the end.
  initial begin : responder2
    ack2 = 1'b0; rdata2 = 8'h00;
    forever begin
      @(negedge clk);
      ack2   = rst2_n && req2;
      rdata2 = (req2 && addr2 < 64'd1024) ? mem[addr2[9:0]] : 8'h00;
      if (ack2) n2_acks++;
      if (req2 && addr2 >= 64'd1024) n2_bad++;
    end
  end

  // Expected result of fetching from start_pc, derived from the ISA encoding rules.
  task automatic model_fetch(input logic [63:0] start_pc, input res_t p, output res_t r, output int nbytes);
    logic [3:0]  ic, fn;
    logic [63:0] a;
    logic [7:0]  b;
    int          len, voff;
    bit          reg_b, legal;
    r = p; r.ra = 4'hF; r.rb = 4'hF; r.valc = 64'd0;
    nbytes = 0; len = 1; voff = 0; reg_b = 0; legal = 0;
    for (int i = 0; i < len; i++) begin
      a = start_pc + 64'(i);
      if (a >= 64'd1024) begin r.stat = 3'd3; return; end
      nbytes++;
      b = mem[a[9:0]];
      if (a == err_addr) begin r.stat = 3'd3; return; end
      if (i == 0) begin
        ic = b[7:4]; fn = b[3:0]; r.icode = ic; r.ifun = fn;
        case (ic)
          4'h0, 4'h1, 4'h9: begin len = 1;  legal = (fn == 0); end
          4'h2:             begin len = 2;  legal = (fn <= 6); reg_b = 1; end
          4'h3, 4'h4, 4'h5: begin len = 10; legal = (fn == 0); reg_b = 1; voff = 2; end
          4'h6:             begin len = 2;  legal = (fn <= 3); reg_b = 1; end
          4'h7:             begin len = 9;  legal = (fn <= 6); voff = 1; end
          4'h8:             begin len = 9;  legal = (fn == 0); voff = 1; end
          4'hA, 4'hB:       begin len = 2;  legal = (fn == 0); reg_b = 1; end
          default:          legal = 0;
        endcase
        if (!legal) begin r.stat = 3'd4; r.valp = start_pc + 64'd1; return; end
      end else begin
        if (reg_b && i == 1) begin r.ra = b[7:4]; r.rb = b[3:0]; end
        if (voff > 0 && i >= voff) r.valc = r.valc | (64'(b) << (8 * (i - voff)));
      end
    end
    r.valp = start_pc + 64'(len);
    r.stat = (r.icode == 4'h0) ? 3'd2 : 3'd1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (instr_valid) begin ok = 1; return; end
    end
  endtask

  task automatic pulse_load(input logic [63:0] a);
    @(negedge clk);
    pc_load = 1'b1; new_pc = a;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    acked.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    res_t act;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (act !== rst_res) $display("FAIL reset_fields: got %h want %h", act, rst_res); else n_pass++;
    n_checks++;
    if ({pc, mem_req, mem_addr, instr_valid} !== {64'd0, 1'b0, 64'd0, 1'b0})
      $display("FAIL reset_ctrl: got pc=%h req=%b addr=%h valid=%b want 0/0/0/0", pc, mem_req, mem_addr, instr_valid);
    else n_pass++;
    @(negedge clk);
    acked.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 64'd0})
      $display("FAIL first_req: got req=%b addr=%h want 1/0", mem_req, mem_addr);
    else n_pass++;
  endtask

  task automatic test_irmovq();
    res_t exp, act;
    int   nb;
    bit   ok, seq;
    model_fetch(64'd0, rst_res, exp, nb);
    wait_valid(200, ok);
    n_checks++;
    if (!ok) $display("FAIL irmovq_timeout: got valid=%b want 1", instr_valid); else n_pass++;
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (act !== exp) $display("FAIL irmovq_fields: got %h want %h", act, exp); else n_pass++;
    seq = (acked.size() == 10);
    foreach (acked[i]) if (acked[i] !== 64'(i)) seq = 0;
    n_checks++;
    if (!seq) $display("FAIL irmovq_reqs: got %0d reqs want 10 at 0..9", acked.size()); else n_pass++;
    prev = exp;
  endtask

  task automatic test_jmp();
    res_t exp, act;
    int   nb;
    bit   ok;
    acked.delete();
    model_fetch(64'h20, prev, exp, nb);
    pulse_load(64'h20);
    n_checks++;
    if ({instr_valid, pc} !== {1'b0, 64'h20})
      $display("FAIL load_pc: got valid=%b pc=%h want 0/20", instr_valid, pc);
    else n_pass++;
    @(negedge clk);
    pc_load = 1'b1; new_pc = 64'h3FF;
    repeat (3) @(negedge clk);
    pc_load = 1'b0;
    wait_valid(200, ok);
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (!ok || act !== exp || pc !== 64'h20 || acked.size() != nb)
      $display("FAIL jmp: got %h pc=%h n=%0d want %h pc=20 n=%0d", act, pc, acked.size(), exp, nb);
    else n_pass++;
    n_checks++;
    if ({ValC, ValP} !== {64'h100, 64'h29})
      $display("FAIL jmp_const: got %h/%h want 100/29", ValC, ValP);
    else n_pass++;
    prev = exp;
  endtask

  task automatic test_random_stream();
    res_t        exp, act;
    int          nb, ic;
    bit          ok, seq;
    logic [63:0] a;
    max_delay = 3;
    for (int it = 0; it < 16; it++) begin
      a  = 64'($urandom_range(64, 900));
      ic = int'($urandom_range(1, 11));
      mem[a[9:0]] = {4'(ic), (ic == 2 || ic == 7) ? 4'($urandom_range(0, 6)) :
                             (ic == 6) ? 4'($urandom_range(0, 3)) : 4'h0};
      for (int k = 1; k < 10; k++) mem[a[9:0] + 10'(k)] = 8'($urandom);
      model_fetch(a, prev, exp, nb);
      acked.delete();
      pulse_load(a);
      wait_valid(200, ok);
      act = {icode, ifun, rA, rB, ValC, ValP, stat};
      n_checks++;
      if (!ok || act !== exp) $display("FAIL rand_fields[%0d]: got %h want %h", it, act, exp); else n_pass++;
      seq = (acked.size() == nb);
      foreach (acked[i]) if (acked[i] !== a + 64'(i)) seq = 0;
      n_checks++;
      if (!seq) $display("FAIL rand_reqs[%0d]: got %0d reqs want %0d from %h", it, acked.size(), nb, a); else n_pass++;
      n_checks++;
      if (pc !== a) $display("FAIL rand_pc[%0d]: got %h want %h", it, pc, a); else n_pass++;
      prev = exp;
    end
    max_delay = 0;
  endtask

  task automatic test_halt();
    res_t exp, act;
    int   nb;
    bit   ok;
    mem[0] = 8'h00;
    model_fetch(64'd0, rst_res, exp, nb);
    do_reset();
    wait_valid(100, ok);
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (!ok || act !== exp || acked.size() != 1)
      $display("FAIL halt: got %h n=%0d want %h n=1", act, acked.size(), exp);
    else n_pass++;
    for (int i = 0; i < 3; i++) pulse_load(64'h40);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pc, mem_req, instr_valid, stat} !== {64'd0, 1'b0, 1'b1, 3'd2})
      $display("FAIL halt_hold: got pc=%h req=%b valid=%b stat=%0d want 0/0/1/2", pc, mem_req, instr_valid, stat);
    else n_pass++;
  endtask

  task automatic test_ins();
    logic [7:0] ops [6];
    res_t       exp, act;
    int         nb;
    bit         ok;
    ops = '{8'h67, 8'hC0, 8'h27, 8'h64, 8'h31, 8'hF0};
    foreach (ops[j]) begin
      mem[0] = ops[j];
      model_fetch(64'd0, rst_res, exp, nb);
      do_reset();
      wait_valid(100, ok);
      act = {icode, ifun, rA, rB, ValC, ValP, stat};
      n_checks++;
      if (!ok || act !== exp || acked.size() != 1)
        $display("FAIL ins_%h: got %h n=%0d want %h n=1", ops[j], act, acked.size(), exp);
      else n_pass++;
      n_checks++;
      if ({stat, ValP, mem_req} !== {3'd4, 64'd1, 1'b0})
        $display("FAIL ins_stat_%h: got stat=%0d valp=%h req=%b want 4/1/0", ops[j], stat, ValP, mem_req);
      else n_pass++;
    end
  endtask

  task automatic test_adr();
    res_t exp, act;
    int   nb;
    bit   ok;
    model_fetch(64'd1022, rst_res, exp, nb);
    for (int i = 0; i < 50 && !valid2; i++) @(posedge clk);
    #1;
    act = {icode2, ifun2, ra2, rb2, valc2, valp2, stat2};
    n_checks++;
    if (!valid2 || act !== exp || stat2 !== 3'd3)
      $display("FAIL adr_end: got %h valid=%b want %h", act, valid2, exp);
    else n_pass++;
    n_checks++;
    if (n2_acks != 2 || n2_bad != 0 || req2 !== 1'b0 || pc2 !== 64'd1022)
      $display("FAIL adr_reqs: got acks=%0d bad=%0d req=%b pc=%h want 2/0/0/3fe", n2_acks, n2_bad, req2, pc2);
    else n_pass++;
    mem[0] = 8'h30; mem[1] = 8'hF3;
    for (int k = 2; k < 10; k++) mem[k] = 8'($urandom);
    err_addr = 64'd1;
    model_fetch(64'd0, rst_res, exp, nb);
    do_reset();
    wait_valid(100, ok);
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (!ok || act !== exp || acked.size() != 2 || stat !== 3'd3)
      $display("FAIL mem_err: got %h n=%0d want %h n=2", act, acked.size(), exp);
    else n_pass++;
    err_addr = '1;
  endtask

  task automatic test_reset_mid_fetch();
    res_t exp, act;
    int   nb;
    bit   ok, found, seq;
    mem[0] = 8'h30; mem[1] = {4'hF, 4'($urandom)};
    for (int k = 2; k < 10; k++) mem[k] = 8'($urandom);
    model_fetch(64'd0, rst_res, exp, nb);
    max_delay = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acked.size() == 4 && mem_req) begin found = 1; break; end
    end
    n_checks++;
    if (!found || mem_addr !== 64'd4) $display("FAIL mid_reach: got n=%0d addr=%h want 4/4", acked.size(), mem_addr); else n_pass++;
    #1;
    rst_n = 1'b0; late_ack_en = 1'b1;
    #1;
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (act !== rst_res || {pc, mem_req, mem_addr, instr_valid} !== {64'd0, 1'b0, 64'd0, 1'b0})
      $display("FAIL mid_reset: got %h pc=%h req=%b want %h pc=0 req=0", act, pc, mem_req, rst_res);
    else n_pass++;
    repeat (2) @(negedge clk);
    acked.delete();
    max_delay = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    late_ack_en = 1'b0;
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 64'd0}) $display("FAIL late_ack: got req=%b addr=%h want 1/0", mem_req, mem_addr); else n_pass++;
    wait_valid(200, ok);
    act = {icode, ifun, rA, rB, ValC, ValP, stat};
    n_checks++;
    if (!ok || act !== exp) $display("FAIL refetch: got %h want %h", act, exp); else n_pass++;
    seq = (acked.size() == 10);
    foreach (acked[i]) if (acked[i] !== 64'(i)) seq = 0;
    n_checks++;
    if (!seq) $display("FAIL refetch_reqs: got %0d reqs want 10 at 0..9", acked.size()); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n2_acks = 0; n2_bad = 0;
    rst_n = 1'b0; rst2_n = 1'b0; pc_load = 1'b0; new_pc = 64'd0;
    max_delay = 0; late_ack_en = 1'b0; err_addr = '1;
    rst_res = '{icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0, stat: 3'd1};
    prev = rst_res;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    mem[32] = 8'h70; mem[33] = 8'h00; mem[34] = 8'h01;
    mem[1022] = 8'h30; mem[1023] = 8'hF3;
    #23 rst2_n = 1'b1;
    test_reset();
    test_irmovq();
    test_jmp();
    test_random_stream();
    test_halt();
    test_ins();
    test_adr();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
SEQ fetch stage with PC register, directly upstream of pc_update. Holds the current PC and reads a Y86-64 instruction one byte at a time from a byte-wide instruction memory using a req/ack handshake. Splits out icode/ifun/rA/rB/ValC, computes ValP, and reports stat. Consumes newPc from pc_update to begin the next fetch.

Parameters:
RESET_PC, 0, PC value loaded on reset.
IMEM_SIZE, 1024, instruction memory size in bytes. Any address >= IMEM_SIZE is an address error.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
pc_load  input  1  one-cycle pulse; accept new_pc and start the next fetch. Honoured only in DONE.
new_pc  input  64  next PC (newPc from pc_update).
mem_req  output  1  byte read request.
mem_addr  output  64  byte address; stable while mem_req=1.
mem_rdata  input  8  read data; valid when mem_ack=1.
mem_ack  input  1  completes the current byte request.
mem_err  input  1  memory fault; qualified by mem_ack.
pc  output  64  PC of the instruction being fetched or held.
icode  output  4  instruction code.
ifun  output  4  function code.
rA  output  4  register A; 0xF if the instruction has no register byte.
rB  output  4  register B; 0xF if the instruction has no register byte.
ValC  output  64  constant, little-endian; 0 if absent.
ValP  output  64  pc + instruction length.
stat  output  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
instr_valid  output  1  high in DONE; all decoded outputs stable while high.

Behaviour:
- Reset (async, rst_n=0) forces:
  - pc=RESET_PC; mem_req=0; mem_addr=0;
  - icode=ifun=0; rA=rB=0xF; ValC=0; ValP=0;
  - stat=1; instr_valid=0; byte count=0; state=FETCH.
  - On deassertion, the first request goes out on the next rising edge.
- States: FETCH, DONE, HALT, ERR.
- FETCH, request rules:
  - mem_req=1 with mem_addr=pc+n, where n is the byte index (0..9).
  - If pc+n >= IMEM_SIZE: issue no request, set stat=3, go to ERR.
  - A byte is accepted on any edge with mem_req=1 and mem_ack=1.
  - Back-to-back bytes are allowed: mem_req stays high and mem_addr increments the cycle after an ack.
  - mem_err=1 with mem_ack=1: stat=3, go to ERR.
- FETCH, byte 0 decode:
  - icode=rdata[7:4], ifun=rdata[3:0].
  - Instruction length by icode:
    - 0, 1, 9 -> 1 byte.
    - 2, 6, A, B -> 2 bytes.
    - 7, 8 -> 9 bytes.
    - 3, 4, 5 -> 10 bytes.
    - icode > 0xB -> INS, length 1.
  - Illegal ifun -> INS, length 1:
    - opq (6): ifun > 3.
    - jXX (7) or cmov (2): ifun > 6.
    - any other icode: ifun != 0.
  - An INS instruction goes to ERR after byte 0.
- FETCH, later bytes:
  - Register byte (byte 1 for icode 2..6, A, B): rA=[7:4], rB=[3:0].
  - ValC bytes fill little-endian: byte k of the constant goes to ValC[8k+7:8k].
    - icode 7 and 8: constant is bytes 1..8.
    - icode 3..5: constant is bytes 2..9.
- FETCH, completion: the cycle after the last byte, ValP=pc+length (64-bit wrap).
  - icode 0 -> stat=2, go to HALT.
  - Otherwise stat=1, go to DONE.
- DONE:
  - instr_valid=1; mem_req=0.
  - On pc_load: pc<=new_pc, byte count<=0, rA=rB=0xF, ValC=0, go to FETCH. instr_valid is 0 in the following cycle.
  - pc_load in any other state is ignored.
- HALT and ERR:
  - instr_valid=1; mem_req=0; all outputs held.
  - Terminal until reset; pc_load is ignored.
- Reset mid-fetch: the outstanding request is abandoned; a late mem_ack after reset is ignored in the first cycle.
- Simultaneous mem_ack and pc_load while in FETCH: the ack is processed and pc_load is ignored.

Test Plan:
1. Reset, memory holds 30 F3 0A 00 00 00 00 00 00 00 at address 0 with ack every cycle -> 10 reqs at addresses 0..9; DONE with icode=3, rA=F, rB=3, ValC=0x0A, ValP=10, stat=1.
2. In DONE, pulse pc_load with new_pc=0x20; memory[0x20]=70 00 01 00 00 00 00 00 00 (jmp) -> 9 bytes fetched; icode=7, ifun=0, ValC=0x100, ValP=0x29.
3. Memory[0]=00 -> a single request; stat=2, state HALT; further pc_load pulses leave pc=0 and mem_req=0.
4. Byte 0=0x67 (opq, ifun 7) -> stat=4 after one byte; ERR with ValP=1. Separately, byte 0=0xC0 -> stat=4.
5. RESET_PC=IMEM_SIZE-2 with a 10-byte irmovq -> 2 bytes fetched, then stat=3 with no third request. Separately, mem_err with ack on byte 1 -> stat=3.
6. Random 0-3 cycle ack delays plus rst_n asserted during byte 4 of a 10-byte fetch -> outputs at reset values immediately; refetch starts from RESET_PC and its results match a zero-delay fetch.
